// File: rtl/handshake_pkg.sv
// Shared definitions for the handshake_vnr1 register-sliced valid/ready pipeline.
package handshake_pkg;

  localparam int DEFAULT_VALUE_BITS = 8;
  localparam int DEFAULT_DEPTH      = 2;

  // Encoding of {input transfer, output transfer} used by the occupancy counter.
  typedef enum logic [1:0] {
    XFER_NONE = 2'b00,
    XFER_OUT  = 2'b01,
    XFER_IN   = 2'b10,
    XFER_BOTH = 2'b11
  } xfer_e;

  // Width needed to represent an occupancy of 0..depth+1.
  function automatic int count_bits(input int depth);
    return $clog2(depth + 2);
  endfunction

endpackage

// File: rtl/handshake_stage.sv
// One forward-registered valid/ready stage; ready is combinational so bubbles
// collapse within a single cycle.
module handshake_stage #(
  parameter int VALUE_BITS = 8
) (
  input  logic                  clock,
  input  logic                  reset_n,
  input  logic                  up_valid,
  input  logic [VALUE_BITS-1:0] up_value,
  output logic                  up_ready,
  output logic                  dn_valid,
  output logic [VALUE_BITS-1:0] dn_value,
  input  logic                  dn_ready
);

  assign up_ready = ~dn_valid | dn_ready;

  // Load when empty or draining; payload only moves with a valid word.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      dn_valid <= 1'b0;
      dn_value <= '0;
    end else if (up_ready) begin
      dn_valid <= up_valid;
      if (up_valid) begin
        dn_value <= up_value;
      end
    end
  end

endmodule

// File: rtl/handshake_vnr1.sv
// DEPTH forward-registered stages fronted by a one-entry skid buffer, so both
// the downstream outputs and o_ready come straight from flops.
// Optional feature: define HANDSHAKE_VNR1_COUNT_EN to add the o_count
// occupancy port and its up/down counter.
module handshake_vnr1
  import handshake_pkg::*;
#(
  parameter int VALUE_BITS = DEFAULT_VALUE_BITS,
  parameter int DEPTH      = DEFAULT_DEPTH
) (
  input  logic                  clock,
  input  logic                  reset_n,
  input  logic [VALUE_BITS-1:0] i_value,
  input  logic                  i_valid,
  output logic                  o_ready,
  output logic [VALUE_BITS-1:0] o_value,
  output logic                  o_valid,
  input  logic                  i_ready
`ifdef HANDSHAKE_VNR1_COUNT_EN
  ,
  output logic [count_bits(DEPTH)-1:0] o_count
`endif
);

  if (DEPTH < 1) begin : g_bad_depth
    $error("handshake_vnr1: DEPTH must be >= 1");
  end
  if (VALUE_BITS < 1) begin : g_bad_width
    $error("handshake_vnr1: VALUE_BITS must be >= 1");
  end

  logic                  in_xfer;
  logic                  out_xfer;
  logic                  rdy0;
  logic                  skid_valid;
  logic                  skid_valid_next;
  logic                  skid_load;
  logic [VALUE_BITS-1:0] skid_value;
  logic [DEPTH:0]        valid_chain;
  logic [VALUE_BITS-1:0] value_chain [DEPTH+1];

  assign in_xfer  = i_valid & o_ready;
  assign out_xfer = o_valid & i_ready;

  // Stage 0 is fed from the skid entry first, otherwise from the live input.
  assign valid_chain[0] = skid_valid | in_xfer;
  assign value_chain[0] = skid_valid ? skid_value : i_value;

  for (genvar k = 0; k < DEPTH; k++) begin : g_stage
    logic up_rdy;
    logic dn_rdy;

    if (k == DEPTH - 1) begin : g_last
      assign dn_rdy = i_ready;
    end else begin : g_mid
      assign dn_rdy = g_stage[k+1].up_rdy;
    end

    handshake_stage #(
      .VALUE_BITS(VALUE_BITS)
    ) u_stage (
      .clock   (clock),
      .reset_n (reset_n),
      .up_valid(valid_chain[k]),
      .up_value(value_chain[k]),
      .up_ready(up_rdy),
      .dn_valid(valid_chain[k+1]),
      .dn_value(value_chain[k+1]),
      .dn_ready(dn_rdy)
    );
  end

  assign rdy0    = g_stage[0].up_rdy;
  assign o_valid = valid_chain[DEPTH];
  assign o_value = value_chain[DEPTH];

  // Skid fills when a word arrives that stage 0 cannot take, empties once it can.
  always_comb begin
    skid_valid_next = skid_valid;
    skid_load       = 1'b0;
    if (skid_valid) begin
      if (rdy0) begin
        skid_valid_next = 1'b0;
      end
    end else if (in_xfer && !rdy0) begin
      skid_valid_next = 1'b1;
      skid_load       = 1'b1;
    end
  end

  // Skid storage and the registered upstream ready derived from its next state.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      skid_valid <= 1'b0;
      skid_value <= '0;
      o_ready    <= 1'b0;
    end else begin
      skid_valid <= skid_valid_next;
      if (skid_load) begin
        skid_value <= i_value;
      end
      o_ready <= ~skid_valid_next;
    end
  end

`ifdef HANDSHAKE_VNR1_COUNT_EN
  localparam int CW = count_bits(DEPTH);

  logic [CW-1:0] count_q;
  xfer_e         xfer;

  assign xfer    = xfer_e'({in_xfer, out_xfer});
  assign o_count = count_q;

  // Occupancy over stages plus skid; simultaneous in/out leaves it unchanged.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      count_q <= '0;
    end else begin
      case (xfer)
        XFER_IN:  count_q <= count_q + 1'b1;
        XFER_OUT: count_q <= count_q - 1'b1;
        default:  count_q <= count_q;
      endcase
    end
  end

  a_count_matches : assert property (@(posedge clock) disable iff (!reset_n)
    count_q == CW'($countones(valid_chain[DEPTH:1]) + int'(skid_valid)));

  a_count_range : assert property (@(posedge clock) disable iff (!reset_n)
    count_q <= CW'(DEPTH + 1));
`endif

endmodule

// File: tb/tb_handshake_vnr1.sv
// Directed and random bench for handshake_vnr1 (DEPTH=2, VALUE_BITS=8).
module tb_handshake_vnr1;
  import handshake_pkg::*;

  localparam int VALUE_BITS   = 8;
  localparam int DEPTH        = 2;
  localparam int STREAM_WORDS = 16;
  localparam int NUM_RANDOM   = 2000;
  localparam int RANDOM_LIMIT = 30000;

  logic                  clock   = 1'b0;
  logic                  reset_n = 1'b0;
  logic [VALUE_BITS-1:0] i_value = '0;
  logic                  i_valid = 1'b0;
  logic                  i_ready = 1'b0;
  logic                  o_ready;
  logic [VALUE_BITS-1:0] o_value;
  logic                  o_valid;
`ifdef HANDSHAKE_VNR1_COUNT_EN
  logic [count_bits(DEPTH)-1:0] o_count;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clock = ~clock;

  handshake_vnr1 #(
    .VALUE_BITS(VALUE_BITS),
    .DEPTH     (DEPTH)
  ) dut (
    .clock  (clock),
    .reset_n(reset_n),
    .i_value(i_value),
    .i_valid(i_valid),
    .o_ready(o_ready),
    .o_value(o_value),
    .o_valid(o_valid),
    .i_ready(i_ready)
`ifdef HANDSHAKE_VNR1_COUNT_EN
    ,
    .o_count(o_count)
`endif
  );

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    i_valid = 1'b0;
    i_ready = 1'b0;
    #2;
    checks++;
    if (o_valid !== 1'b0) begin errors++; $display("[TB] FAIL reset_o_valid got %b want 0", o_valid); end
    checks++;
    if (o_value !== 8'h00) begin errors++; $display("[TB] FAIL reset_o_value got %h want 00", o_value); end
    checks++;
    if (o_ready !== 1'b0) begin errors++; $display("[TB] FAIL reset_o_ready got %b want 0", o_ready); end
`ifdef HANDSHAKE_VNR1_COUNT_EN
    checks++;
    if (int'(o_count) !== 0) begin errors++; $display("[TB] FAIL reset_o_count got %0d want 0", o_count); end
`endif
    @(negedge clock);
    reset_n = 1'b1;
    #1;
    checks++;
    if (o_ready !== 1'b0) begin errors++; $display("[TB] FAIL release_o_ready_before_edge got %b want 0", o_ready); end
    tick();
    checks++;
    if (o_ready !== 1'b1) begin errors++; $display("[TB] FAIL release_o_ready_after_edge got %b want 1", o_ready); end
    for (int c = 0; c < 4; c++) begin
      checks++;
      if (o_valid !== 1'b0) begin errors++; $display("[TB] FAIL idle_o_valid cycle %0d got %b want 0", c, o_valid); end
      tick();
    end
  endtask

  task automatic test_stream();
    logic exp_valid;
    i_ready = 1'b1;
    for (int c = 0; c < STREAM_WORDS + DEPTH + 3; c++) begin
      i_valid = (c < STREAM_WORDS);
      if (c < STREAM_WORDS) i_value = 8'(c + 1);
      exp_valid = (c >= DEPTH) && (c - DEPTH < STREAM_WORDS);
      if (c < STREAM_WORDS) begin
        checks++;
        if (o_ready !== 1'b1) begin errors++; $display("[TB] FAIL stream_o_ready cycle %0d got %b want 1", c, o_ready); end
      end
      checks++;
      if (o_valid !== exp_valid) begin errors++; $display("[TB] FAIL stream_o_valid cycle %0d got %b want %b", c, o_valid, exp_valid); end
      if (exp_valid) begin
        checks++;
        if (o_value !== 8'(c - DEPTH + 1)) begin
          errors++; $display("[TB] FAIL stream_o_value cycle %0d got %h want %h", c, o_value, 8'(c - DEPTH + 1));
        end
      end
      tick();
    end
    i_valid = 1'b0;
  endtask

  task automatic test_fill();
    int accepted;
    accepted = 0;
    i_ready  = 1'b0;
    for (int c = 0; c < 6; c++) begin
      i_valid = (accepted < DEPTH + 1);
      i_value = 8'(8'hA0 + accepted);
      if (i_valid && o_ready) accepted++;
      tick();
    end
    i_valid = 1'b0;
    checks++;
    if (accepted !== DEPTH + 1) begin errors++; $display("[TB] FAIL fill_accepted got %0d want %0d", accepted, DEPTH + 1); end
    checks++;
    if (o_ready !== 1'b0) begin errors++; $display("[TB] FAIL fill_o_ready got %b want 0", o_ready); end
    checks++;
    if (o_valid !== 1'b1) begin errors++; $display("[TB] FAIL fill_o_valid got %b want 1", o_valid); end
    checks++;
    if (o_value !== 8'hA0) begin errors++; $display("[TB] FAIL fill_o_value got %h want a0", o_value); end
`ifdef HANDSHAKE_VNR1_COUNT_EN
    checks++;
    if (int'(o_count) !== DEPTH + 1) begin errors++; $display("[TB] FAIL fill_o_count got %0d want %0d", o_count, DEPTH + 1); end
`endif
    i_ready = 1'b1;
    for (int c = 0; c < DEPTH + 3; c++) begin
      checks++;
      if (o_valid !== (c <= DEPTH)) begin errors++; $display("[TB] FAIL drain_o_valid cycle %0d got %b want %b", c, o_valid, (c <= DEPTH)); end
      if (c <= DEPTH) begin
        checks++;
        if (o_value !== 8'(8'hA0 + c)) begin errors++; $display("[TB] FAIL drain_o_value cycle %0d got %h want %h", c, o_value, 8'(8'hA0 + c)); end
      end
      if (c == 1) begin
        checks++;
        if (o_ready !== 1'b1) begin errors++; $display("[TB] FAIL drain_o_ready got %b want 1", o_ready); end
      end
      tick();
    end
`ifdef HANDSHAKE_VNR1_COUNT_EN
    checks++;
    if (int'(o_count) !== 0) begin errors++; $display("[TB] FAIL drain_o_count got %0d want 0", o_count); end
`endif
  endtask

  task automatic test_random();
    logic [VALUE_BITS-1:0] sb[$];
    logic [VALUE_BITS-1:0] expv;
    logic [VALUE_BITS-1:0] stall_value;
    int sent, received, cycles, occ;
    bit holding, stall;
    sent = 0; received = 0; cycles = 0; occ = 0;
    holding = 1'b0; stall = 1'b0; stall_value = '0;
    while (received < NUM_RANDOM && cycles < RANDOM_LIMIT) begin
      if (!holding) begin
        i_valid = (sent < NUM_RANDOM) && ($urandom_range(1) == 1);
        if (i_valid) i_value = 8'($urandom);
      end
      i_ready = ($urandom_range(1) == 1);
      if (stall) begin
        checks++;
        if (o_valid !== 1'b1 || o_value !== stall_value) begin
          errors++; $display("[TB] FAIL random_hold cycle %0d got %b/%h want 1/%h", cycles, o_valid, o_value, stall_value);
        end
      end
`ifdef HANDSHAKE_VNR1_COUNT_EN
      checks++;
      if (int'(o_count) !== occ) begin errors++; $display("[TB] FAIL random_o_count cycle %0d got %0d want %0d", cycles, o_count, occ); end
`endif
      if (o_valid && i_ready) begin
        checks++;
        if (sb.size() == 0) begin
          errors++; $display("[TB] FAIL random_spurious cycle %0d got %h want none", cycles, o_value);
        end else begin
          expv = sb.pop_front();
          if (o_value !== expv) begin errors++; $display("[TB] FAIL random_order word %0d got %h want %h", received, o_value, expv); end
        end
        received++;
        occ--;
      end
      if (i_valid && o_ready) begin
        sb.push_back(i_value);
        sent++;
        occ++;
        holding = 1'b0;
      end else begin
        holding = i_valid;
      end
      stall       = o_valid && !i_ready;
      stall_value = o_value;
      tick();
      cycles++;
    end
    i_valid = 1'b0;
    i_ready = 1'b1;
    checks++;
    if (received !== NUM_RANDOM) begin errors++; $display("[TB] FAIL random_timeout got %0d words want %0d", received, NUM_RANDOM); end
    tick();
    tick();
  endtask

  task automatic test_reset_midstream();
    int accepted;
    accepted = 0;
    i_ready  = 1'b0;
    for (int c = 0; c < 6; c++) begin
      i_valid = (accepted < 3);
      i_value = 8'(8'hC0 + accepted);
      if (i_valid && o_ready) accepted++;
      tick();
    end
    i_valid = 1'b0;
    #2;
    reset_n = 1'b0;
    #1;
    checks++;
    if (o_valid !== 1'b0) begin errors++; $display("[TB] FAIL midreset_o_valid got %b want 0", o_valid); end
    checks++;
    if (o_ready !== 1'b0) begin errors++; $display("[TB] FAIL midreset_o_ready got %b want 0", o_ready); end
    @(negedge clock);
    reset_n = 1'b1;
    tick();
    checks++;
    if (o_ready !== 1'b1) begin errors++; $display("[TB] FAIL midreset_release_o_ready got %b want 1", o_ready); end
    i_ready = 1'b1;
    for (int c = 0; c < 6; c++) begin
      checks++;
      if (o_valid !== 1'b0) begin errors++; $display("[TB] FAIL midreset_stale cycle %0d got %b want 0", c, o_valid); end
      tick();
    end
    i_valid = 1'b1;
    i_value = 8'h5A;
    tick();
    i_valid = 1'b0;
    for (int c = 0; c < DEPTH + 2; c++) begin
      checks++;
      if (o_valid !== (c == DEPTH - 1)) begin errors++; $display("[TB] FAIL midreset_new_valid cycle %0d got %b want %b", c, o_valid, (c == DEPTH - 1)); end
      if (c == DEPTH - 1) begin
        checks++;
        if (o_value !== 8'h5A) begin errors++; $display("[TB] FAIL midreset_new_value got %h want 5a", o_value); end
      end
      tick();
    end
  endtask

  initial begin
    test_reset();
    test_stream();
    test_fill();
    test_random();
    test_reset_midstream();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
